// File: rtl/prog_loader_pkg.sv
// Shared symbols for the boot-image loader: FSM encoding and frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prog_loader_pkg;

    // Loader phases: length byte, image body, checksum byte, released, error.
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Byte that pulls the loader out of the error state.
    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

    // A length byte of this value means "fill the whole RAM".
    localparam logic [7:0] LEN_FULL = 8'h00;

    // The checksum is the mod-256 sum of the body bytes, starting from here.
    localparam logic [7:0] SUM_INIT = 8'h00;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream boot loader: LEN, N body bytes written to RAM, checksum, then CPU release.
// Latency: RAM write strobe one cycle after each body-byte transfer; status flags registered.
// Backpressure: rx_ready high in LEN/DATA/CSUM/ERR (from the first edge after reset), low in RUN.
//
// Ports:
//   clk, reset         clock and asynchronous active-low reset
//   rx_valid/rx_data   upstream byte stream, rx_ready back to it
//   ram_we/ram_addr/ram_data  one-cycle RAM write port
//   cpu_run            CPU release, high only after a good checksum
//   load_err           checksum mismatch, cleared by a SYNC byte
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              cpu_run,
    output logic              load_err
);

    // Remaining-byte counter must hold both any 8-bit length and 2^ADDR_W.
    localparam int CNT_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam logic [CNT_W-1:0] FULL_CNT = {{(CNT_W-1){1'b0}}, 1'b1} << ADDR_W;

    state_t             state_q;
    state_t             state_d;
    logic               ready_en_q;   // gates rx_ready until the first edge after reset
    logic [CNT_W-1:0]   rem_q;        // body bytes still expected
    logic [ADDR_W-1:0]  addr_q;       // next RAM address to write
    logic [7:0]         sum_q;        // running checksum of the body
    logic               xfer;
    logic               last_data;
    logic [CNT_W-1:0]   len_target;

    assign rx_ready   = ready_en_q && (state_q != ST_RUN);
    assign xfer       = rx_valid && rx_ready;
    assign last_data  = (rem_q == {{(CNT_W-1){1'b0}}, 1'b1});
    assign len_target = (rx_data == LEN_FULL) ? FULL_CNT : CNT_W'(rx_data);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN: begin
                if (xfer) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (xfer && last_data) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (xfer) state_d = (rx_data == sum_q) ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_ERR: begin
                if (xfer && (rx_data == SYNC)) state_d = ST_LEN;
            end
            default: begin
                state_d = ST_LEN;
            end
        endcase
    end

    // Datapath: counters, checksum, RAM write port and registered status flags.
    // The last body byte's write is issued from the DATA branch on the same edge
    // the FSM moves to CSUM, so it is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            rem_q      <= '0;
            addr_q     <= '0;
            sum_q      <= SUM_INIT;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= 8'h00;
            cpu_run    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            ram_we     <= 1'b0;
            cpu_run    <= (state_d == ST_RUN);
            load_err   <= (state_d == ST_ERR);
            case (state_q)
                ST_LEN: begin
                    if (xfer) begin
                        rem_q  <= len_target;
                        addr_q <= '0;
                        sum_q  <= SUM_INIT;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        ram_we   <= 1'b1;
                        ram_addr <= addr_q;
                        ram_data <= rx_data;
                        addr_q   <= addr_q + 1'b1;
                        sum_q    <= sum_q + rx_data;
                        rem_q    <= rem_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames plus randomized frames with
// corrupted checksums, resync and idle insertion, compared against a stream-level model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       cpu_run;
    logic       load_err;

    prog_loader #(.ADDR_W(8), .SYNC(8'h55)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int we_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", ram_addr, ram_data);
            end else begin
                mon_e = sb.pop_front();
                if (ram_addr !== mon_e.addr[7:0] || ram_data !== mon_e.data[7:0] || cyc != mon_e.cyc) begin
                    fails++;
                    $display("FAIL ram_write: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                             ram_addr, ram_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Stream-level reference: where we are in the frame, not how the RTL encodes it.
    // mode 0: want length, 1: in body, 2: want checksum, 3: released, 4: error
    int m_mode = 0;
    int m_rem  = 0;
    int m_sum  = 0;
    int m_addr = 0;

    task automatic model_byte(input logic [7:0] b, output int wa);
        wa = -1;
        case (m_mode)
            0: begin
                m_rem  = (b == 8'h00) ? 256 : int'(b);
                m_sum  = 0;
                m_addr = 0;
                m_mode = 1;
            end
            1: begin
                wa     = m_addr;
                m_addr = (m_addr + 1) % 256;
                m_sum  = (m_sum + int'(b)) % 256;
                m_rem  = m_rem - 1;
                if (m_rem == 0) m_mode = 2;
            end
            2: m_mode = (int'(b) == m_sum) ? 3 : 4;
            4: if (b == 8'h55) m_mode = 0;
            default: ;
        endcase
    endtask

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit idle_before, input bit rst_after);
        int n;
        int c;
        int wa;
        if (idle_before) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got rx_ready=%0b for byte %0h, required 1", rx_ready, b);
            rx_valid = 1'b0;
            return;
        end
        c = cyc;
        model_byte(b, wa);
        @(posedge clk);
        if (rst_after) begin
            #1 reset = 1'b0;
        end else if (wa >= 0) begin
            sb.push_back('{wa, int'(b), c + 1});
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [7:0] stim[$];

    task automatic send_stream(input int idle_mode);
        bit idle;
        foreach (stim[i]) begin
            idle = (idle_mode == 1) ? 1'b1 :
                   (idle_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            send_byte(stim[i], idle, 1'b0);
        end
        stim.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_cpu_run"}, {31'd0, cpu_run}, (m_mode == 3) ? 32'd1 : 32'd0);
        chk({tag, "_load_err"}, {31'd0, load_err}, (m_mode == 4) ? 32'd1 : 32'd0);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_pending_writes"}, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 0);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 0);
        chk({tag, "_ram_addr"}, {24'd0, ram_addr}, 0);
        chk({tag, "_ram_data"}, {24'd0, ram_data}, 0);
        chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 0);
        chk({tag, "_load_err"}, {31'd0, load_err}, 0);
    endtask

    // Release reset at a falling edge; rx_ready may only rise after the next rising edge.
    task automatic release_reset();
        reset = 1'b1;
        m_mode = 0;
        #1 chk("ready_low_after_release", {31'd0, rx_ready}, 0);
        @(negedge clk);
        chk("ready_after_first_edge", {31'd0, rx_ready}, 1);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (check) check_all_zero("reset");
        release_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int w0;
        int len;
        int sum;
        int g;
        logic [7:0] b;

        do_reset(1'b1);

        // Basic frame, back-to-back
        stim = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_stream(0);
        check_status("basic");
        drain("basic");

        // Bad checksum, then resync and a good one-byte frame
        do_reset(1'b0);
        stim = '{8'h02, 8'h10, 8'h20, 8'h31};
        send_stream(0);
        check_status("bad_csum");
        chk("bad_csum_in_err", {31'd0, load_err}, 1);
        stim = '{8'h55, 8'h01, 8'hAA, 8'hAA};
        send_stream(0);
        check_status("resync");
        drain("resync");

        // Full-RAM image: length 0 means 256 bytes, every address once
        do_reset(1'b0);
        w0 = we_cnt;
        stim.push_back(8'h00);
        for (int i = 0; i < 256; i++) stim.push_back(8'h01);
        stim.push_back(8'h00);
        send_stream(0);
        check_status("full");
        drain("full");
        chk("full_write_count", we_cnt - w0, 256);

        // rx_valid toggling every cycle
        do_reset(1'b0);
        w0 = we_cnt;
        stim = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_stream(1);
        check_status("toggle");
        drain("toggle");
        chk("toggle_write_count", we_cnt - w0, 4);

        // RUN ignores further input
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("run_rx_ready", {31'd0, rx_ready}, 0);
            chk("run_cpu_run", {31'd0, cpu_run}, 1);
        end
        rx_valid = 1'b0;
        drain("run_idle");

        // Reset right after a body byte is accepted: that write must never appear
        do_reset(1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b1);
        check_all_zero("midload_reset");
        release_reset();
        stim = '{8'h01, 8'h7F, 8'h7F};
        send_stream(0);
        check_status("after_reset");
        drain("after_reset");

        // Randomized frames, optionally corrupted then recovered via SYNC
        for (int r = 0; r < 12; r++) begin
            do_reset(1'b0);
            len = $urandom_range(1, 24);
            sum = 0;
            stim.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                sum = (sum + int'(b)) % 256;
                stim.push_back(b);
            end
            if ($urandom_range(0, 1) == 1) begin
                stim.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
                send_stream(2);
                check_status("rand_bad");
                g = $urandom_range(0, 3);
                for (int i = 0; i < g; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h55) b = 8'h54;
                    stim.push_back(b);
                end
                stim.push_back(8'h55);
                len = $urandom_range(1, 24);
                sum = 0;
                stim.push_back(8'(len));
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(0, 255));
                    sum = (sum + int'(b)) % 256;
                    stim.push_back(b);
                end
            end
            stim.push_back(8'(sum));
            send_stream(2);
            check_status("rand_good");
            drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the RAM address width; the maximum image is 2^ADDR_W bytes.
REQ-002 SHALL have parameter SYNC, default 8'h55, meaning the byte that clears the error state.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_valid  input  1  upstream byte-stream valid.
REQ-007 rx_data  input  8  upstream byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 ram_we  output  1  one-cycle RAM write strobe.
REQ-010 ram_addr  output  ADDR_W  RAM write address.
REQ-011 ram_data  output  8  RAM write data.
REQ-012 cpu_run  output  1  CPU release; held low while loading and in error.
REQ-013 load_err  output  1  checksum mismatch flag.

Function
REQ-014 SHALL define a transfer as rx_valid && rx_ready sampled at a rising clk edge; rx_data is captured only on a transfer.
REQ-015 SHALL implement states LEN, DATA, CSUM, RUN and ERR.
REQ-016 LEN: rx_ready=1; on a transfer, latch N=rx_data (0 means 2^ADDR_W), clear addr and sum, go to DATA.
REQ-017 DATA: rx_ready=1; on each transfer, register addr/data, add the byte to the 8-bit sum (mod 256), increment addr; after the Nth byte go to CSUM.
REQ-018 SHALL assert ram_we for exactly one cycle, in the cycle after each DATA transfer, with ram_addr/ram_data stable for that cycle (latency 1).
REQ-019 SHALL accept back-to-back DATA transfers every cycle with no bubbles; rx_valid low inserts idle cycles, and no write occurs without a transfer.
REQ-020 CSUM: rx_ready=1; on a transfer, compare rx_data with sum; on a match go to RUN, else go to ERR.
REQ-021 RUN: cpu_run=1, rx_ready=0, ram_we=0; RUN is left only by reset.
REQ-022 ERR: load_err=1, cpu_run=0, rx_ready=1; a transfer of SYNC clears load_err and goes to LEN; other bytes are dropped.
REQ-023 SHALL wrap the address counter within ADDR_W bits; when N=0, addresses 0..2^ADDR_W-1 are each written exactly once.
REQ-024 SHALL complete the pending DATA write when the transfer carrying the last byte occurs, even though the state moves to CSUM the same edge.
REQ-025 SHALL latch cpu_run and load_err; neither toggles combinationally from rx_data.

Reset
REQ-026 SHALL, while reset=0, force state=LEN, rx_ready=0, ram_we=0, ram_addr=0, ram_data=0, cpu_run=0, load_err=0, sum=0, N=0.
REQ-027 SHALL drop any pending RAM write on a reset assertion mid-load and not emit it after release.
REQ-028 SHALL raise rx_ready no earlier than the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the state encoding enum, the SYNC default and the LEN/CSUM framing constants in the shared symbols package.
REQ-030 SHALL be a single module with no sub-module; the checksum accumulator is inline.

Verification
REQ-031 Stream 03,11,22,33,66 -> writes (0,11),(1,22),(2,33) one cycle after each transfer; cpu_run=1 after the 66 transfer; load_err=0.
REQ-032 Stream 02,10,20,31 -> two writes; load_err=1, cpu_run=0; then 55,01,AA,AA -> load_err=0, write (0,AA), cpu_run=1.
REQ-033 Stream 00 followed by 256 bytes 0x01 and checksum 00 -> 256 writes at addresses 00..FF with no address repeated; cpu_run=1.
REQ-034 Stream 04,01,02,03,04,0A with rx_valid toggling 1/0 each cycle -> exactly 4 ram_we pulses; cpu_run=1.
REQ-035 Stream 05,AA,BB, then reset low for 1 cycle -> no write after reset; all outputs 0; a new stream 01,7F,7F loads correctly.
REQ-036 In RUN, drive rx_valid=1 with rx_data=55 for 10 cycles -> rx_ready=0, no ram_we, cpu_run stays 1.
